// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: rptr synchroniser, binary/Gray write pointer, full/level flags.
// Define ASYNC_FIFO_GRAY_CHECK_EN to add the sticky wgray_err checker on the synchronised read pointer.
module async_fifo_wr_ctrl #(
    parameter int ADDRSIZE     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
`ifdef ASYNC_FIFO_GRAY_CHECK_EN
    ,
    output logic                wgray_err
`endif
);

    localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [SYNC_STAGES-1:0][ADDRSIZE:0] sync_q;
    logic [ADDRSIZE:0] wq_rptr, wq_rbin;
    logic [ADDRSIZE:0] wbin, wbin_next, wgray_next, level_next, full_cmp;

    // Plain flop chain: nothing may sit between stages or the Gray guarantee is lost.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rptr;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    always_comb begin
        wq_rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++)
            wq_rbin[i] = ^(wq_rptr >> i);
    end

    assign wen        = winc & ~wfull;
    assign wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign level_next = wbin_next - wq_rbin;
    // Full when the write pointer is exactly one lap ahead of the (stale) read pointer.
    assign full_cmp   = {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]};
    assign waddr      = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_cmp);
            walmost_full <= (level_next >= THRESH);
            wlevel       <= level_next;
            wovf         <= winc & wfull;
        end
    end

`ifdef ASYNC_FIFO_GRAY_CHECK_EN
    logic [ADDRSIZE:0] wq_rptr_d, gray_diff;

    assign gray_diff = wq_rptr ^ wq_rptr_d;

    // More than one bit set in the sample-to-sample difference is a broken Gray sequence.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq_rptr_d <= '0;
            wgray_err <= 1'b0;
        end else begin
            wq_rptr_d <= wq_rptr;
            if ((gray_diff & (gray_diff - 1'b1)) != '0)
                wgray_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Randomised bench for async_fifo_wr_ctrl against a count-based occupancy model.
module tb_async_fifo_wr_ctrl;
    localparam int AW = 4;
    localparam int S  = 2;
    localparam int AF = 12;
    localparam int DEPTH = 1 << AW;
    localparam int PMASK = (2 * DEPTH) - 1;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   rptr;
    logic [AW:0]   wptr;
    logic [AW-1:0] waddr;
    logic          wen, wfull, walmost_full, wovf;
    logic [AW:0]   wlevel;
`ifdef ASYNC_FIFO_GRAY_CHECK_EN
    logic          wgray_err;
`endif

    async_fifo_wr_ctrl #(.ADDRSIZE(AW), .SYNC_STAGES(S), .AFULL_THRESH(AF)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr), .wptr(wptr), .waddr(waddr),
        .wen(wen), .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
`ifdef ASYNC_FIFO_GRAY_CHECK_EN
        , .wgray_err(wgray_err)
`endif
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int fails  = 0;

    // model: counts of accepted writes and issued reads, plus the rptr history seen by the sync chain
    int wcnt, rd_cnt;
    int rq[$];
    bit m_full, m_af, m_ovf;
    int m_lvl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return (b >> 1) ^ b;
    endfunction

    task automatic model_reset();
        wcnt = 0; rd_cnt = 0; rq.delete();
        repeat (S) rq.push_back(0);
        m_full = 0; m_af = 0; m_ovf = 0; m_lvl = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".wptr"},  32'(wptr),   32'(gray(wcnt)));
        chk({tag, ".waddr"}, 32'(waddr),  32'(wcnt % DEPTH));
        chk({tag, ".wfull"}, 32'(wfull),  32'(m_full));
        chk({tag, ".waf"},   32'(walmost_full), 32'(m_af));
        chk({tag, ".wlevel"},32'(wlevel), 32'(m_lvl));
        chk({tag, ".wovf"},  32'(wovf),   32'(m_ovf));
    endtask

    // Drive at negedge, clock once, update model, compare at the following negedge.
    task automatic step(input bit w, input bit rd_adv, input string tag);
        logic [AW:0] prev_wptr;
        int used;
        prev_wptr = wptr;
        winc = w;
        if (rd_adv && rd_cnt < wcnt) rd_cnt++;
        rptr = gray(rd_cnt);
        #1 chk({tag, ".wen"}, 32'(wen), 32'(w & ~m_full));
        @(posedge wclk);
        used = rq.pop_front();
        rq.push_back(rd_cnt);
        m_ovf = w && m_full;
        if (w && !m_full) wcnt++;
        m_lvl  = (wcnt - used) & PMASK;
        m_full = (m_lvl == DEPTH);
        m_af   = (m_lvl >= AF);
        @(negedge wclk);
        chk_outputs(tag);
        chk({tag, ".gray1"}, 32'($countones(prev_wptr ^ wptr) <= 1), 32'd1);
    endtask

    task automatic chk_reset_zero(input string tag);
        chk({tag, ".wptr"},  32'(wptr), 0);
        chk({tag, ".waddr"}, 32'(waddr), 0);
        chk({tag, ".wfull"}, 32'(wfull), 0);
        chk({tag, ".waf"},   32'(walmost_full), 0);
        chk({tag, ".wlevel"},32'(wlevel), 0);
        chk({tag, ".wovf"},  32'(wovf), 0);
    endtask

    initial begin
        int n;
        wrst_n = 1'b0; winc = 1'b0; rptr = '0;
        model_reset();
        #1 chk_reset_zero("rst0");
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;

        // mid-stream reset at level 7
        for (int i = 0; i < 7; i++) step(1, 0, "pre");
        chk("lvl7", 32'(wlevel), 32'd7);
        winc = 1'b1;
        #2 wrst_n = 1'b0;
        #1 chk_reset_zero("rst_async");
        winc = 1'b0;
        @(negedge wclk);
        chk_reset_zero("rst_hold");
        model_reset();
        wrst_n = 1'b1;
        step(0, 0, "post_rst");

        // fill from empty with rptr held at 0
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, "fill");
            chk("fill.af_edge", 32'(walmost_full), 32'(i >= AF));
            chk("fill.full_edge", 32'(wfull), 32'(i == DEPTH));
        end
        chk("fill.wlevel16", 32'(wlevel), 32'(DEPTH));
        step(1, 0, "ovf");
        chk("ovf.pulse", 32'(wovf), 1);
        chk("ovf.wptr", 32'(wptr), 32'b11000);
        step(1, 0, "ovf2");
        chk("ovf2.pulse", 32'(wovf), 1);
        step(0, 0, "ovf_end");
        chk("ovf_end.pulse", 32'(wovf), 0);

        // drain visibility: one read advance, full should drop after S+1 edges
        n = 0;
        step(0, 1, "drain");
        n = 1;
        while (wfull && n < 10) begin
            step(0, 0, "drain");
            n++;
        end
        chk("drain.edges", 32'(n), 32'(S + 1));
        chk("drain.wlevel", 32'(wlevel), 32'(DEPTH - 1));

        // bring level to 8 and let the read side settle
        while (rd_cnt < wcnt - 8) step(0, 1, "to8");
        repeat (S + 1) step(0, 0, "to8");
        chk("lvl8", 32'(wlevel), 32'd8);
        // write lands on the edge the synced read advance arrives
        step(0, 1, "simul");
        for (int i = 1; i < S; i++) step(0, 0, "simul");
        step(1, 0, "simul");
        chk("simul.wlevel", 32'(wlevel), 32'd8);

        // random traffic: a window biased to keep level low (wrap), then free-running
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 1) == 1, (wcnt - rd_cnt) > 4 || $urandom_range(0, 3) == 0, "wrap");
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, "rand");

`ifdef ASYNC_FIFO_GRAY_CHECK_EN
        winc = 1'b0;
        wrst_n = 1'b0;
        #1;
        chk("gerr.rst", 32'(wgray_err), 0);
        rptr = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
        repeat (S + 1) @(negedge wclk);
        chk("gerr.clean", 32'(wgray_err), 0);
        rptr = 5'b00011;
        repeat (S + 2) @(negedge wclk);
        chk("gerr.set", 32'(wgray_err), 1);
        rptr = 5'b00010;
        repeat (4) @(negedge wclk);
        chk("gerr.sticky", 32'(wgray_err), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
